// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule expander.
// Loads 16 message words, then streams W[0..NUM_WORDS-1].
module sig0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
endmodule

module sha256_msg_sched #(
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic {LOAD, EMIT} state_e;

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  in_cnt_q, in_cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] s0, s1, w_next;
  logic        in_fire, out_fire;

  function automatic logic [31:0] sig1_f(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  sig0 u_sig0 (
    .x (w_q[1]),
    .y (s0)
  );

  assign s1     = sig1_f(w_q[14]);
  assign w_next = s1 + w_q[9] + s0 + w_q[0];

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_data  = w_q[0];
  assign out_idx   = t_q;
  assign out_last  = (state_q == EMIT) && (t_q == LAST_IDX);
  assign busy      = (state_q == EMIT) || (in_cnt_q != 4'd0);

  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    t_d      = t_q;
    w_d      = w_q;
    if (abort) begin
      state_d  = LOAD;
      in_cnt_d = 4'd0;
      t_d      = 6'd0;
    end else if (in_fire) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15]  = in_data;
      in_cnt_d = in_cnt_q + 4'd1;
      if (in_cnt_q == 4'd15) begin
        state_d  = EMIT;
        in_cnt_d = 4'd0;
        t_d      = 6'd0;
      end
    end else if (out_fire) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = w_next;
      t_d     = t_q + 6'd1;
      if (t_q == LAST_IDX) begin
        state_d = LOAD;
        t_d     = 6'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      in_cnt_q <= 4'd0;
      t_q      <= 6'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      t_q      <= t_d;
      w_q      <= w_d;
    end
  end
endmodule
